serial_sub: RTL
===============

# serial_sub

Bit-serial, LSB-first subtractor computing `a - b` one bit per clock, with a single borrow flip-flop between bits. It is the inverse-operation companion to the team's combinational half adder (`sum`/`carry`) and trades area for latency. Results are captured in output registers and held stable between operations. A start/busy/done handshake lets a small controller or the tile's `ui_in`/`uo_out` pins drive it.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend; sampled on the accepting edge.
- `b`  in  WIDTH  subtrahend; sampled on the accepting edge.
- `busy`  out  1  high while bits are being processed.
- `done`  out  1  one-cycle pulse; result registers updated this cycle.
- `diff`  out  WIDTH  `(a - b) mod 2^WIDTH`.
- `borrow_out`  out  1  1 when `a < b` (unsigned).
- `ovf`  out  1  two's-complement signed overflow of `a - b`.
- `zero`  out  1  1 when `diff == 0`.

## Operation
- **Reset values:** all outputs are 0, the FSM is in IDLE, internal shift registers are 0, and the borrow flip-flop is 0.
- **FSM states:** IDLE → SHIFT → DONE → IDLE.
- **IDLE:**
  - `start=1` at an edge loads `a`/`b` into the internal shift registers `sa`/`sb`.
  - The same edge clears the borrow flip-flop `br` and sets the bit counter to 0.
  - It also latches `a[WIDTH-1]` and `b[WIDTH-1]` for overflow detection, then goes to SHIFT.
- **SHIFT:** each cycle processes one bit.
  - `d = sa[0] ^ sb[0] ^ br`
  - `br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)`
  - `sa` and `sb` shift right.
  - An internal result shift register shifts right with `d` inserted at the MSB.
  - The counter increments.
  - When the counter equals WIDTH-1, this cycle processes the last bit, and the next state is DONE.
- **DONE:** lasts exactly one cycle.
  - `done=1`.
  - `diff` ← the internal result register.
  - `borrow_out` ← `br`.
  - `zero` ← (result == 0).
  - `ovf` ← `(a_msb != b_msb) && (result[WIDTH-1] != a_msb)`.
  - Next state is IDLE.
- **Output stability:** `diff`/`borrow_out`/`ovf`/`zero` hold the previous result until the next DONE. They never show partial results.
- **`start` outside IDLE:** ignored in SHIFT and DONE, with no queuing.
- **`a`/`b` after acceptance:** may change freely; they have no effect until the next accepted start.
- **Counter:** `$clog2(WIDTH)` bits; there is no wrap within an operation.
- **`rst` at any time:** takes priority over everything. It aborts the operation, returns the FSM to IDLE and clears all outputs, including held results; no `done` is issued.

## Timing
- `start` sampled at edge k → `busy`=1 from after edge k through the cycle ending at edge k+WIDTH (WIDTH cycles).
- `done`=1 for the single cycle after edge k+WIDTH.
- The result registers change at edge k+WIDTH+1.
- `busy` and `done` are never high together. `busy` is low in IDLE and DONE.
- The next start can be accepted at edge k+WIDTH+2 at the earliest, giving a minimum issue interval of WIDTH+2 cycles.
- `rst` asserted at edge r: all outputs are 0 after edge r. `start` at edge r+1 is accepted normally.

## Test plan
- **Basic subtraction (WIDTH=8):** `a=200`, `b=55`, single start → `busy` high for 8 cycles; `done` pulse in cycle 9; `diff=145`, `borrow_out=0`, `ovf=0`, `zero=0`.
- **Borrow:** `a=5`, `b=9` → `diff=0xFC`, `borrow_out=1`, `ovf=0`, `zero=0`.
- **Equal operands and signed overflow:**
  - `a=b=0x5A` → `diff=0`, `zero=1`, `borrow_out=0`.
  - `a=0x80`, `b=0x01` → `diff=0x7F`, `ovf=1`, `borrow_out=0`.
  - `a=0x7F`, `b=0xFF` → `diff=0x80`, `ovf=1`, `borrow_out=1`.
- **Ignored start and stable inputs/outputs:**
  - Pulse `start` with new operands in SHIFT cycle 3 and in the DONE cycle → both ignored.
  - The first result is correct; `busy` returns low.
  - Changing `a`/`b` during SHIFT does not affect the result.
  - The previous result stays unchanged until `done`.
- **Reset mid-operation:** `a=100`, `b=1`, `rst` at SHIFT cycle 4 → no `done`; all outputs 0 on the next cycle; a new start with `a=3`, `b=3` gives `zero=1` at the expected cycle.
- **Back-to-back and exhaustive:**
  - Issue starts every WIDTH+2 cycles over 256 random pairs, then run exhaustively over all 65536 pairs.
  - `diff`, `borrow_out`, `ovf` and `zero` must match a reference model on every `done`.

Source files
------------

// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The controller side uses the master modport; the subtractor uses slave.
interface serial_sub_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             ovf;
   logic             zero;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow_out, ovf, zero
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow_out, ovf, zero
   );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial LSB-first subtractor: diff = a - b, one bit per clock through a
// single borrow flip-flop. Results land in output registers on the cycle after
// the done pulse and are held until the next operation completes.
module serial_sub #(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   serial_sub_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_reg;
   state_t           state_next;

   logic [WIDTH-1:0] sa_reg;
   logic [WIDTH-1:0] sb_reg;
   logic [WIDTH-1:0] res_reg;
   logic             br_reg;
   logic [CW-1:0]    cnt_reg;
   logic             a_msb_reg;
   logic             b_msb_reg;

   logic [WIDTH-1:0] diff_reg;
   logic             borrow_reg;
   logic             ovf_reg;
   logic             zero_reg;

   logic             bit_d;
   logic             br_next;
   logic             last_bit;

   // One full-subtractor slice operating on the current LSBs.
   assign bit_d    = sa_reg[0] ^ sb_reg[0] ^ br_reg;
   assign br_next  = (~sa_reg[0] & sb_reg[0]) | (~(sa_reg[0] ^ sb_reg[0]) & br_reg);
   assign last_bit = (cnt_reg == CW'(WIDTH - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; start is only looked at while idle, so no queuing.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.start) state_next = SHIFT;
         SHIFT:   if (last_bit)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand load, serial datapath and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         sa_reg     <= '0;
         sb_reg     <= '0;
         res_reg    <= '0;
         br_reg     <= 1'b0;
         cnt_reg    <= '0;
         a_msb_reg  <= 1'b0;
         b_msb_reg  <= 1'b0;
         diff_reg   <= '0;
         borrow_reg <= 1'b0;
         ovf_reg    <= 1'b0;
         zero_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  sa_reg    <= bus.a;
                  sb_reg    <= bus.b;
                  res_reg   <= '0;
                  br_reg    <= 1'b0;
                  cnt_reg   <= '0;
                  a_msb_reg <= bus.a[WIDTH-1];
                  b_msb_reg <= bus.b[WIDTH-1];
               end
            end
            SHIFT: begin
               sa_reg  <= {1'b0, sa_reg[WIDTH-1:1]};
               sb_reg  <= {1'b0, sb_reg[WIDTH-1:1]};
               res_reg <= {bit_d, res_reg[WIDTH-1:1]};
               br_reg  <= br_next;
               // Hold the counter on the last bit so it never wraps.
               if (!last_bit) begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            DONE: begin
               diff_reg   <= res_reg;
               borrow_reg <= br_reg;
               zero_reg   <= (res_reg == '0);
               // Signed overflow: operands of differing sign and a result whose
               // sign differs from the minuend.
               ovf_reg    <= (a_msb_reg != b_msb_reg) && (res_reg[WIDTH-1] != a_msb_reg);
            end
            default: ;
         endcase
      end
   end

   assign bus.busy       = (state_reg == SHIFT);
   assign bus.done       = (state_reg == DONE);
   assign bus.diff       = diff_reg;
   assign bus.borrow_out = borrow_reg;
   assign bus.ovf        = ovf_reg;
   assign bus.zero       = zero_reg;
endmodule
